mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Parametrised multi-cycle CPU control unit, successor to the current fixed-timing controller. Decodes the instruction opcode and sequences fetch/decode/execute/memory/write-back. It adds:
- ready/request handshakes to instruction and data memory, with unbounded wait states;
- a sticky HALT state;
- illegal-opcode detection;
- a retired-instruction counter.

It sits between the IR opcode field and the datapath muxes/write enables (PC, IR, register file, ALU, ALUOut, data memory).

## Interface
Parameters:
- OP_W, 6, opcode width; opcode values below are the low 6 bits, upper bits must be zero, otherwise illegal
- CNT_W, 32, retired-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OP_W  IR opcode field, stable from ID onward
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access completes this cycle
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- pc_wre  out  1  PC write enable
- ir_wre  out  1  IR write enable
- reg_wre  out  1  register-file write enable
- reg_dst  out  2  write-register select: 00 = r31, 01 = rt, 10 = rd
- wr_reg_data  out  1  write-data select: 0 = PC+4, 1 = ALU/mem
- mem_to_reg  out  1  write-data source: 1 = memory, 0 = ALUOut
- alu_src_b  out  1  ALU B operand: 0 = rt, 1 = extended immediate
- alu_op  out  3  ALU function: 000 add, 001 sub, 010 slt, 100 sll, 101 or, 110 and
- ext_sel  out  1  1 = sign-extend, 0 = zero-extend
- sa_ext  out  1  immediate taken from the sa field
- pc_src  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target
- state  out  4  current state code
- halted  out  1  in HALT state
- illegal  out  1  sticky flag: illegal opcode decoded
- retired  out  CNT_W  count of retired instructions, wraps

## Operation
Opcodes:
- add 000000, sub 000001, addi 000010
- or 010000, and 010001, ori 010010
- sll 011000, move 100000, slt 100111
- sw 110000, lw 110001, beq 110100
- j 111000, jr 111001, jal 111010, halt 111111
- any other value is illegal

State codes: IF 0, ID 1, EXR 2, EXB 3, EXA 4, MEM 5, WBR 6, WBL 7, HALT 8.

All outputs are combinational from (state, opcode, zero, ready). Any output not listed for a state is 0 there, except reg_dst = 10.

State behaviour:
- **IF:** imem_req = 1.
  - imem_ready = 1: ir_wre = 1, go to ID.
  - imem_ready = 0: stay in IF.
- **ID:**
  - addi, ori, beq, lw, sw: ext_sel = 1.
  - R-type, addi, ori, sll: go to EXR.
  - beq: go to EXB.
  - lw, sw: go to EXA.
  - j: pc_wre = 1, pc_src = 11, go to IF.
  - jal: as j, plus reg_wre = 1, reg_dst = 00, wr_reg_data = 0.
  - jr: pc_wre = 1, pc_src = 10, go to IF.
  - halt: go to HALT.
  - illegal opcode: set illegal, go to HALT.
- **EXR:** alu_op per opcode (move = add). addi/ori/sll: alu_src_b = 1. sll: sa_ext = 1. Go to WBR.
- **EXB:** alu_op = 001, pc_wre = 1, pc_src = zero ? 01 : 00. Go to IF.
- **EXA:** alu_op = 000, alu_src_b = 1. Go to MEM.
- **MEM:** dmem_req = 1, dmem_we = (opcode == sw).
  - Waits while dmem_ready = 0.
  - On dmem_ready: sw asserts pc_wre = 1 and goes to IF; lw goes to WBL.
- **WBR:** reg_wre = 1, pc_wre = 1, wr_reg_data = 1. reg_dst = 01 for addi/ori, 10 otherwise. Go to IF.
- **WBL:** reg_wre = 1, pc_wre = 1, wr_reg_data = 1, mem_to_reg = 1, reg_dst = 01. Go to IF.
- **HALT:** halted = 1; all enables and requests 0. Stays in HALT until reset.

Counter and flags:
- retired increments by 1 (mod 2^CNT_W) on every edge where pc_wre = 1.
- illegal sets on the ID edge that decodes an illegal opcode and clears only on reset.

## Timing
Reset:
- state = IF, retired = 0, illegal = 0.
- Resulting outputs: imem_req = 1, all other 1-bit outputs 0, reg_dst = 10, pc_src = 00, alu_op = 000.
- Reset wins over every other event, including mid-wait in IF/MEM and in HALT.

Latency with zero wait states (cycles from IF entry to IF re-entry):
- j / jr / jal: 2
- beq: 3
- R-type and immediate ALU ops: 4
- sw: 4
- lw: 5

Handshakes:
- Each wait cycle in IF or MEM adds exactly 1 cycle.
- A request stays asserted until its ready is seen.
- Ready while not requesting is ignored.

Branch resolution: zero is sampled combinationally in EXB; pc_wre and pc_src are valid in the same cycle.

## Test plan
- Reset held 2 cycles, then released with imem_ready = 1, opcode add, 3 instructions → state sequence 0,1,2,6 repeated; retired = 3 after 12 cycles; reg_wre high only in WBR, with reg_dst = 10.
- lw with dmem_ready low for 3 MEM cycles → MEM lasts 4 cycles with dmem_req = 1 and dmem_we = 0; WBL has mem_to_reg = 1, reg_dst = 01; total 8 cycles.
- beq with zero = 1, then beq with zero = 0 → EXB pc_src = 01, then 00; pc_wre = 1 both times; alu_op = 001.
- jal → ID has reg_wre = 1, reg_dst = 00, wr_reg_data = 0, pc_src = 11, pc_wre = 1; next state IF.
- Opcode 000111 → HALT; illegal = 1 and halted = 1 held for 10 cycles with all enables 0; reset clears both.
- CNT_W = 4, 17 j instructions → retired wraps to 1; reset asserted mid-MEM wait → state 0 on the next edge with dmem_req = 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Memory handshake bundle between the control FSM (master) and the
// instruction/data memory side (slave).
interface mc_ctrl_fsm_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic dmem_we;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control unit: IF/ID/EX/MEM/WB sequencing with memory
// handshakes, sticky HALT, illegal-opcode flag and retired-instruction counter.
module mc_ctrl_fsm #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_fsm_if.master    mem,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    output logic             pc_wre,
    output logic             ir_wre,
    output logic             reg_wre,
    output logic [1:0]       reg_dst,
    output logic             wr_reg_data,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [2:0]       alu_op,
    output logic             ext_sel,
    output logic             sa_ext,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXB = 4'd3, S_EXA = 4'd4,
        S_MEM = 4'd5, S_WBR = 4'd6, S_WBL = 4'd7, S_HALT = 4'd8
    } state_t;

    state_t     cur, nxt;
    logic [5:0] op;
    logic       hi_zero, legal;
    logic       legal_op, is_alu, is_imm, is_sll, is_beq, is_lw, is_sw;
    logic       is_j, is_jal, is_jr;
    logic [2:0] alu_fn;
    logic       imem_req, dmem_req, dmem_we;

    assign op = opcode[5:0];

    // Opcode bits above the 6-bit field must be zero for a legal decode.
    if (OP_W > 6) begin : g_hi
        assign hi_zero = ~|opcode[OP_W-1:6];
    end else begin : g_nohi
        assign hi_zero = 1'b1;
    end

    always_comb begin
        legal_op = 1'b1;
        is_alu = 1'b0; is_imm = 1'b0; is_sll = 1'b0; is_beq = 1'b0;
        is_lw = 1'b0;  is_sw = 1'b0;  is_j = 1'b0;   is_jal = 1'b0; is_jr = 1'b0;
        alu_fn = 3'b000;
        case (op)
            6'b000000: is_alu = 1'b1;                                  // add
            6'b000001: begin is_alu = 1'b1; alu_fn = 3'b001; end       // sub
            6'b000010: begin is_alu = 1'b1; is_imm = 1'b1; end         // addi
            6'b010000: begin is_alu = 1'b1; alu_fn = 3'b101; end       // or
            6'b010001: begin is_alu = 1'b1; alu_fn = 3'b110; end       // and
            6'b010010: begin is_alu = 1'b1; is_imm = 1'b1; alu_fn = 3'b101; end
            6'b011000: begin is_alu = 1'b1; is_sll = 1'b1; alu_fn = 3'b100; end
            6'b100000: is_alu = 1'b1;                                  // move
            6'b100111: begin is_alu = 1'b1; alu_fn = 3'b010; end       // slt
            6'b110000: is_sw  = 1'b1;
            6'b110001: is_lw  = 1'b1;
            6'b110100: is_beq = 1'b1;
            6'b111000: is_j   = 1'b1;
            6'b111001: is_jr  = 1'b1;
            6'b111010: is_jal = 1'b1;
            6'b111111: ;                                               // halt
            default:   legal_op = 1'b0;
        endcase
    end

    assign legal = hi_zero & legal_op;

    always_comb begin
        nxt = cur;
        imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
        pc_wre = 1'b0; ir_wre = 1'b0; reg_wre = 1'b0; reg_dst = 2'b10;
        wr_reg_data = 1'b0; mem_to_reg = 1'b0; alu_src_b = 1'b0; alu_op = 3'b000;
        ext_sel = 1'b0; sa_ext = 1'b0; pc_src = 2'b00; halted = 1'b0;
        case (cur)
            S_IF: begin
                imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_wre = 1'b1;
                    nxt    = S_ID;
                end
            end
            S_ID: begin
                if (!legal) nxt = S_HALT;
                else begin
                    ext_sel = is_imm | is_beq | is_lw | is_sw;
                    if (is_alu)              nxt = S_EXR;
                    else if (is_beq)         nxt = S_EXB;
                    else if (is_lw || is_sw) nxt = S_EXA;
                    else if (is_j || is_jal) begin
                        pc_wre = 1'b1; pc_src = 2'b11; nxt = S_IF;
                        if (is_jal) begin
                            reg_wre = 1'b1; reg_dst = 2'b00;
                        end
                    end else if (is_jr) begin
                        pc_wre = 1'b1; pc_src = 2'b10; nxt = S_IF;
                    end else nxt = S_HALT;
                end
            end
            S_EXR: begin
                alu_op    = alu_fn;
                alu_src_b = is_imm | is_sll;
                sa_ext    = is_sll;
                nxt       = S_WBR;
            end
            S_EXB: begin
                alu_op = 3'b001;
                pc_wre = 1'b1;
                pc_src = zero ? 2'b01 : 2'b00;
                nxt    = S_IF;
            end
            S_EXA: begin
                alu_src_b = 1'b1;
                nxt       = S_MEM;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (mem.dmem_ready) begin
                    pc_wre = is_sw;
                    nxt    = is_sw ? S_IF : S_WBL;
                end
            end
            S_WBR: begin
                reg_wre = 1'b1; pc_wre = 1'b1; wr_reg_data = 1'b1;
                reg_dst = is_imm ? 2'b01 : 2'b10;
                nxt     = S_IF;
            end
            S_WBL: begin
                reg_wre = 1'b1; pc_wre = 1'b1; wr_reg_data = 1'b1;
                mem_to_reg = 1'b1; reg_dst = 2'b01;
                nxt = S_IF;
            end
            S_HALT:  halted = 1'b1;
            default: nxt = S_IF;
        endcase
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign state        = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_IF;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (pc_wre) retired <= retired + CNT_W'(1);
            if (cur == S_ID && !legal) illegal <= 1'b1;
        end
    end
endmodule
